// File: rtl/inj_sched_pkg.sv
// Shared types and constants for the injection scheduler and its skid FIFO.
package inj_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } inj_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // FIFO entry layout, MSB first: {last, src, data}
    function automatic int entry_width(input int dw, input int sw);
        return 1 + sw + dw;
    endfunction

endpackage

// File: rtl/inj_skid_fifo.sv
// Two-entry synchronous skid FIFO with registered head output and occupancy count.
module inj_skid_fifo
    import inj_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [W-1:0]          data_i,
    input  logic                  pop_i,
    output logic [W-1:0]          data_o,
    output logic                  valid_o,
    output logic [SKID_CNT_W-1:0] count_o
);

    logic [W-1:0]          head_q, head_d;
    logic [W-1:0]          tail_q, tail_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pop_s;
    logic                  push_s;

    assign pop_s  = pop_i && (cnt_q != '0);
    assign push_s = push_i && (pop_s || (cnt_q != SKID_CNT_W'(SKID_DEPTH)));

    // Next-state for head/tail storage and occupancy
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == '0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                cnt_d = cnt_q + SKID_CNT_W'(1);
            end
            2'b01: begin
                if (cnt_q == SKID_CNT_W'(2)) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                cnt_d = cnt_q - SKID_CNT_W'(1);
            end
            2'b11: begin
                if (cnt_q == SKID_CNT_W'(1)) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Storage and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/inject_sched.sv
// Sequences NUM_SRC one-shot dataout buffers onto a router injection port.
// Optional idle watchdog per grant: define INJ_SCHED_WDOG_EN.
module inject_sched
    import inj_sched_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DW          = 20,
    parameter int BURST_LEN   = 30
`ifdef INJ_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 64
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_SRC-1:0]         src_mask,
    output logic [NUM_SRC-1:0]         src_enable,
    input  logic [NUM_SRC*DW-1:0]      src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [DW-1:0]              out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(NUM_SRC)-1:0] out_src,
    output logic                       busy,
    output logic                       all_done,
    output logic                       err
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int EW = entry_width(DW, SW);

    inj_state_e            state_q, state_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [SW-1:0]         grant_q, grant_d;
    logic [CW-1:0]         rcv_q, rcv_d;

    logic [SW-1:0]         lowest_s;
    logic [DW-1:0]         sel_data_s;
    logic                  sel_valid_s;
    logic                  push_s, pop_s, en_s, last_s, room_s, wdog_hit_s;
    logic [SKID_CNT_W-1:0] fifo_cnt_s;
    logic [SKID_CNT_W:0]   occ_next_s;
    logic [EW-1:0]         fifo_in_s, fifo_out_s;

    // Lowest pending source; scanning downward lets the lowest index win
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_s = SW'(i);
            end else begin
                lowest_s = lowest_s;
            end
        end
    end

    // Granted source data/valid mux
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SW'(i)) begin
                sel_data_s  = src_data[i*DW +: DW];
                sel_valid_s = src_valid[i];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    assign push_s     = (state_q == STREAM) && sel_valid_s;
    assign pop_s      = out_valid && out_ready;
    assign last_s     = (rcv_q == CW'(BURST_LEN - 1));
    // Only enable when the word it requests is guaranteed a free slot
    assign occ_next_s = {1'b0, fifo_cnt_s} + {{SKID_CNT_W{1'b0}}, push_s}
                      - {{SKID_CNT_W{1'b0}}, pop_s};
    assign room_s     = (occ_next_s < (SKID_CNT_W + 1)'(SKID_DEPTH));
    assign en_s       = (state_q == STREAM) && (rcv_q < CW'(BURST_LEN)) && room_s;
    assign fifo_in_s  = {last_s, grant_q, sel_data_s};

    inj_skid_fifo #(
        .W (EW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_s),
        .data_i  (fifo_in_s),
        .pop_i   (pop_s),
        .data_o  (fifo_out_s),
        .valid_o (out_valid),
        .count_o (fifo_cnt_s)
    );

    assign {out_last, out_src, out_data} = fifo_out_s;

`ifdef INJ_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;

    assign wdog_hit_s = en_s && !push_s && (wdog_q == WW'(WDOG_CYCLES - 1));

    // Idle counter: restarts on each received word, advances on enabled cycles
    always_comb begin
        err_d = err_q | wdog_hit_s;
        if (state_q != STREAM) begin
            wdog_d = '0;
        end else if (push_s) begin
            wdog_d = '0;
        end else if (en_s) begin
            wdog_d = wdog_q + WW'(1);
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdog_hit_s = 1'b0;
    assign err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rcv_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            rcv_q     <= rcv_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        rcv_d     = rcv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d = src_mask;
                    state_d   = (src_mask == '0) ? DONE : ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                grant_d = lowest_s;
                rcv_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (push_s) begin
                    rcv_d = rcv_q + CW'(1);
                end else begin
                    rcv_d = rcv_q;
                end
                if ((push_s && last_s) || wdog_hit_s) begin
                    pending_d[grant_q] = 1'b0;
                    state_d            = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                // Leave on the edge that empties the FIFO; no pushes occur here
                if ((fifo_cnt_s == '0) || ((fifo_cnt_s == SKID_CNT_W'(1)) && pop_s)) begin
                    state_d = (pending_q != '0) ? ARB : DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        src_enable = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SW'(i)) begin
                src_enable[i] = en_s;
            end else begin
                src_enable[i] = 1'b0;
            end
        end
        busy     = (state_q == ARB) || (state_q == STREAM) || (state_q == DRAIN);
        all_done = (state_q == DONE);
    end

endmodule

// File: doc/inject_sched.md
Name: inject_sched

Overview:
- Sequences a bank of NUM_SRC dataout ROM buffers, each with an enable/dataout/out_valid interface, onto one router local-injection port.
- Grants one buffer at a time in ascending index order and drives its enable.
- Absorbs the buffer's one-cycle enable-to-data latency with a 2-entry skid FIFO, so the router can backpressure with out_ready.
- Each buffer streams exactly one burst per reset; the scheduler reports when every selected buffer has drained.

Parameters:
- NUM_SRC, 4, number of attached dataout buffers.
- DW, 20, flit width.
- BURST_LEN, 30, words emitted per buffer burst; equals buffer DEPTH.
- WDOG_CYCLES, 64, idle cycles tolerated per grant (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins scheduling; src_mask sampled here.
- src_mask  in  NUM_SRC  sources taking part in this run.
- src_enable  out  NUM_SRC  per-buffer enable; at most one bit high.
- src_data  in  NUM_SRC*DW  buffer dataouts; source i occupies bits [i*DW +: DW].
- src_valid  in  NUM_SRC  buffer out_valid.
- out_data  out  DW  flit to router.
- out_valid  out  1  flit valid.
- out_ready  in  1  router accepts; a transfer occurs when out_valid and out_ready are both high.
- out_last  out  1  marks the final flit of a source burst.
- out_src  out  $clog2(NUM_SRC)  source index of the current flit.
- busy  out  1  high in every state except IDLE and DONE.
- all_done  out  1  high in DONE.
- err  out  1  sticky watchdog error (0 when the feature is absent).

Behaviour:
- Reset, asynchronous: state=IDLE, src_enable=0, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, all_done=0, err=0, FIFO empty, rcv_cnt=0, pending mask=0.
- IDLE: on start, pending=src_mask. If src_mask==0, go to DONE; otherwise go to ARB.
- ARB (1 cycle): grant g = lowest set bit of pending; rcv_cnt=0; go to STREAM.
- STREAM:
  - src_enable[g] = (rcv_cnt < BURST_LEN) && (fifo_count + push - pop < 2), where push = src_valid[g] and pop = out_valid && out_ready in the same cycle.
  - The first enabled cycle only arms the buffer. Words arrive on src_valid[g] one cycle after each later enabled cycle.
  - Each src_valid[g] pushes {src_data[g], g, last} into the FIFO and increments rcv_cnt. last = (rcv_cnt == BURST_LEN-1).
  - src_valid from ungranted sources is ignored.
  - When rcv_cnt reaches BURST_LEN: clear pending[g] and go to DRAIN.
- DRAIN: hold until the FIFO is empty. Then go to ARB if pending != 0, otherwise go to DONE.
- DONE: all_done=1, busy=0. start is ignored; only reset leaves DONE, because the buffers are one-shot.
- start outside IDLE is ignored.
- FIFO:
  - Registered outputs; out_data, out_src and out_last are taken from the head entry.
  - Push and pop in the same cycle are allowed, including when full.
  - The enable rule makes overflow impossible; the bench asserts it never occurs.
- Throughput: 1 flit/cycle with out_ready held high, after 2 cycles of arm/latency per grant.
- Reset mid-burst clears everything. The buffers reset on the same rst, so no partial state survives.

Optional Feature:
- Macro INJ_SCHED_WDOG_EN.
- Defined:
  - A counter clears on every src_valid[g] and counts enabled cycles in STREAM.
  - On reaching WDOG_CYCLES: set err (sticky), drop pending[g], go to DRAIN.
  - out_last is not generated for the truncated burst.
- Undefined: no counter; err tied to 0; STREAM waits indefinitely.

Decomposition:
- Package inj_sched_pkg holds:
  - state enum IDLE/ARB/STREAM/DRAIN/DONE;
  - FIFO entry layout {last, src, data};
  - SKID_DEPTH=2 constant.
- One sub-module: inj_skid_fifo, a 2-entry synchronous FIFO with count output, parameterised on entry width.

Test Plan:
- Buffer 0 preloaded 0x00000, 0x01011, 0x01021, 0x02012, 0x02022, 0x03013, 0x03023, 0x00420, then zeros; src_mask=4'b0001; start with out_ready=1 -> 30 flits in that order with out_src=0; out_last only on flit 30; all_done 1 cycle after last pop.
- src_mask=4'b1010 -> flits 1..30 from src 1, then 30 from src 3; src_enable[0] and src_enable[2] never high; exactly one src_enable bit high at any time.
- out_ready toggled 1,0,0,1 repeating -> still 30 flits with contents and order unchanged; fifo_count never exceeds 2; src_enable low whenever FIFO is full.
- rst pulled low at flit 12 of src 0, then released -> all outputs at reset values; a new start replays src 0 from 0x00000.
- src_mask=0 then start -> all_done=1 one cycle later; no src_enable asserted. A second start while in DONE -> no change.
- With INJ_SCHED_WDOG_EN, src_valid[2] forced low and src_mask=4'b0100 -> err=1 after 64 enabled cycles; state reaches DONE; no out_valid.
